// File: rtl/cc_level_pkg.sv
// Shared definitions for the level sequencer and the level data handler:
// sequencer state encoding, the last level index and the default row counts
// of each level, which also size the data handler's row tables.
package cc_level_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        WIN  = 2'd2
    } seqState_t;

    localparam logic [2:0] LAST_LEVEL = 3'd6;

    localparam int LVL1_LEN_DEFAULT = 8;
    localparam int LVL2_LEN_DEFAULT = 10;
    localparam int LVL3_LEN_DEFAULT = 8;
    localparam int LVL4_LEN_DEFAULT = 15;
    localparam int LVL5_LEN_DEFAULT = 8;
    localparam int LVL6_LEN_DEFAULT = 20;

    // Even levels are play levels where a crash matters; odd levels are banners.
    function automatic logic isPlayLevel(input logic [2:0] lvl);
        return (lvl == 3'd2) || (lvl == 3'd4) || (lvl == 3'd6);
    endfunction

endpackage

// File: rtl/cc_level_sequencer_if.sv
// Control and row-index bundle between the game controller, the level
// sequencer and the level data handler. The master side drives start, tick,
// pause and crash; the sequencer (slave) returns level, row and status pulses.
interface cc_level_sequencer_if #(
    parameter int CURRENTLEVEL_DATAWIDTH  = 3,
    parameter int LEVELPROGRESS_DATAWIDTH = 5
);

    logic                               CC_LEVEL_SEQUENCER_Start_InLow;
    logic                               CC_LEVEL_SEQUENCER_Tick_In;
    logic                               CC_LEVEL_SEQUENCER_Pause_In;
    logic                               CC_LEVEL_SEQUENCER_Crash_In;
    logic [CURRENTLEVEL_DATAWIDTH-1:0]  CC_LEVEL_SEQUENCER_CurrentLvl_OutBus;
    logic [LEVELPROGRESS_DATAWIDTH-1:0] CC_LEVEL_SEQUENCER_LvlProgress_OutBus;
    logic                               CC_LEVEL_SEQUENCER_RowValid_Out;
    logic                               CC_LEVEL_SEQUENCER_LevelDone_Out;
    logic                               CC_LEVEL_SEQUENCER_Win_Out;

    modport master (
        output CC_LEVEL_SEQUENCER_Start_InLow,
        output CC_LEVEL_SEQUENCER_Tick_In,
        output CC_LEVEL_SEQUENCER_Pause_In,
        output CC_LEVEL_SEQUENCER_Crash_In,
        input  CC_LEVEL_SEQUENCER_CurrentLvl_OutBus,
        input  CC_LEVEL_SEQUENCER_LvlProgress_OutBus,
        input  CC_LEVEL_SEQUENCER_RowValid_Out,
        input  CC_LEVEL_SEQUENCER_LevelDone_Out,
        input  CC_LEVEL_SEQUENCER_Win_Out
    );

    modport slave (
        input  CC_LEVEL_SEQUENCER_Start_InLow,
        input  CC_LEVEL_SEQUENCER_Tick_In,
        input  CC_LEVEL_SEQUENCER_Pause_In,
        input  CC_LEVEL_SEQUENCER_Crash_In,
        output CC_LEVEL_SEQUENCER_CurrentLvl_OutBus,
        output CC_LEVEL_SEQUENCER_LvlProgress_OutBus,
        output CC_LEVEL_SEQUENCER_RowValid_Out,
        output CC_LEVEL_SEQUENCER_LevelDone_Out,
        output CC_LEVEL_SEQUENCER_Win_Out
    );

endinterface

// File: rtl/cc_level_sequencer_row_prescaler.sv
// Scroll-tick divider: counts enabled ticks and flags a row step on the tick
// that completes a group of TICKS_PER_ROW. Clear wins over counting so a
// crash or a fresh start always begins a new group from zero.
module cc_row_prescaler #(
    parameter int TICKS_PER_ROW = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic tick,
    input  logic enable,
    input  logic clear,
    output logic step
);

    localparam int                 COUNT_W    = $clog2(TICKS_PER_ROW) + 1;
    localparam logic [COUNT_W-1:0] LAST_COUNT = COUNT_W'(TICKS_PER_ROW - 1);

    logic [COUNT_W-1:0] tickCount;
    logic               advance;
    logic               atLast;

    assign advance = enable && tick;
    assign atLast  = (tickCount == LAST_COUNT);
    assign step    = advance && atLast && !clear;

    // Tick counter: wraps to zero on the step tick, frozen while disabled.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tickCount <= '0;
        end else if (clear) begin
            tickCount <= '0;
        end else if (advance) begin
            tickCount <= atLast ? '0 : tickCount + COUNT_W'(1);
        end
    end

endmodule

// File: rtl/cc_level_sequencer.sv
// Level sequencer: walks banner/play levels 1..6 row by row, paced by the
// scroll tick through a prescaler, then parks in WIN until restarted.
// A crash on a play level restarts that level from its blank row.
module cc_level_sequencer
    import cc_level_pkg::*;
#(
    parameter int CURRENTLEVEL_DATAWIDTH  = 3,
    parameter int LEVELPROGRESS_DATAWIDTH = 5,
    parameter int TICKS_PER_ROW           = 4,
    parameter int LVL1_LEN                = LVL1_LEN_DEFAULT,
    parameter int LVL2_LEN                = LVL2_LEN_DEFAULT,
    parameter int LVL3_LEN                = LVL3_LEN_DEFAULT,
    parameter int LVL4_LEN                = LVL4_LEN_DEFAULT,
    parameter int LVL5_LEN                = LVL5_LEN_DEFAULT,
    parameter int LVL6_LEN                = LVL6_LEN_DEFAULT
) (
    input logic                 CC_LEVEL_SEQUENCER_CLOCK_50,
    input logic                 CC_LEVEL_SEQUENCER_RESET_InHigh,
    cc_level_sequencer_if.slave seqBus
);

    seqState_t  state;
    logic [2:0] currentLvl;
    logic [4:0] lvlProgress;
    logic [4:0] levelLen;
    logic       rowValid;
    logic       levelDone;
    logic       win;

    logic startReq;
    logic playCrash;
    logic stepEnable;
    logic stepClear;
    logic step;

    assign startReq   = !seqBus.CC_LEVEL_SEQUENCER_Start_InLow;
    assign playCrash  = (state == RUN) && seqBus.CC_LEVEL_SEQUENCER_Crash_In
                        && isPlayLevel(currentLvl);
    assign stepEnable = (state == RUN) && !seqBus.CC_LEVEL_SEQUENCER_Pause_In;
    assign stepClear  = playCrash || ((state != RUN) && startReq);

    cc_row_prescaler #(
        .TICKS_PER_ROW(TICKS_PER_ROW)
    ) rowPrescaler (
        .clock (CC_LEVEL_SEQUENCER_CLOCK_50),
        .reset (CC_LEVEL_SEQUENCER_RESET_InHigh),
        .tick  (seqBus.CC_LEVEL_SEQUENCER_Tick_In),
        .enable(stepEnable),
        .clear (stepClear),
        .step  (step)
    );

    // Row count of the level currently being played; idle index maps to zero.
    always_comb begin
        levelLen = 5'd0;
        case (currentLvl)
            3'd1:    levelLen = 5'(LVL1_LEN);
            3'd2:    levelLen = 5'(LVL2_LEN);
            3'd3:    levelLen = 5'(LVL3_LEN);
            3'd4:    levelLen = 5'(LVL4_LEN);
            3'd5:    levelLen = 5'(LVL5_LEN);
            3'd6:    levelLen = 5'(LVL6_LEN);
            default: levelLen = 5'd0;
        endcase
    end

    // Sequencer FSM with registered outputs; pulses default low every cycle.
    always_ff @(posedge CC_LEVEL_SEQUENCER_CLOCK_50 or posedge CC_LEVEL_SEQUENCER_RESET_InHigh) begin
        if (CC_LEVEL_SEQUENCER_RESET_InHigh) begin
            state       <= IDLE;
            currentLvl  <= 3'd0;
            lvlProgress <= 5'd0;
            rowValid    <= 1'b0;
            levelDone   <= 1'b0;
            win         <= 1'b0;
        end else begin
            rowValid  <= 1'b0;
            levelDone <= 1'b0;
            case (state)
                IDLE: begin
                    if (startReq) begin
                        state       <= RUN;
                        currentLvl  <= 3'd1;
                        lvlProgress <= 5'd0;
                    end
                end
                RUN: begin
                    if (playCrash) begin
                        lvlProgress <= 5'd0;
                    end else if (step) begin
                        if (lvlProgress < levelLen) begin
                            lvlProgress <= lvlProgress + 5'd1;
                            rowValid    <= 1'b1;
                        end else begin
                            levelDone   <= 1'b1;
                            lvlProgress <= 5'd0;
                            if (currentLvl == LAST_LEVEL) begin
                                state <= WIN;
                                win   <= 1'b1;
                            end else begin
                                currentLvl <= currentLvl + 3'd1;
                            end
                        end
                    end
                end
                WIN: begin
                    if (startReq) begin
                        state       <= RUN;
                        win         <= 1'b0;
                        currentLvl  <= 3'd1;
                        lvlProgress <= 5'd0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign seqBus.CC_LEVEL_SEQUENCER_CurrentLvl_OutBus  = CURRENTLEVEL_DATAWIDTH'(currentLvl);
    assign seqBus.CC_LEVEL_SEQUENCER_LvlProgress_OutBus = LEVELPROGRESS_DATAWIDTH'(lvlProgress);
    assign seqBus.CC_LEVEL_SEQUENCER_RowValid_Out       = rowValid;
    assign seqBus.CC_LEVEL_SEQUENCER_LevelDone_Out      = levelDone;
    assign seqBus.CC_LEVEL_SEQUENCER_Win_Out            = win;

endmodule

// File: tb/tb_cc_level_sequencer.sv
// Bench for the level sequencer: one instance stepping every tick and one
// dividing by four, both compared each cycle against a game-level model
// that counts ticks and rows with plain integers.
module tb_cc_level_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstFast;
    logic rstSlow;

    cc_level_sequencer_if busFast ();
    cc_level_sequencer_if busSlow ();

    logic drvStartLow [2];
    logic drvTick     [2];
    logic drvPause    [2];
    logic drvCrash    [2];

    assign busFast.CC_LEVEL_SEQUENCER_Start_InLow = drvStartLow[0];
    assign busFast.CC_LEVEL_SEQUENCER_Tick_In     = drvTick[0];
    assign busFast.CC_LEVEL_SEQUENCER_Pause_In    = drvPause[0];
    assign busFast.CC_LEVEL_SEQUENCER_Crash_In    = drvCrash[0];
    assign busSlow.CC_LEVEL_SEQUENCER_Start_InLow = drvStartLow[1];
    assign busSlow.CC_LEVEL_SEQUENCER_Tick_In     = drvTick[1];
    assign busSlow.CC_LEVEL_SEQUENCER_Pause_In    = drvPause[1];
    assign busSlow.CC_LEVEL_SEQUENCER_Crash_In    = drvCrash[1];

    cc_level_sequencer #(.TICKS_PER_ROW(1)) dutFast (
        .CC_LEVEL_SEQUENCER_CLOCK_50    (clk),
        .CC_LEVEL_SEQUENCER_RESET_InHigh(rstFast),
        .seqBus                         (busFast)
    );

    cc_level_sequencer #(.TICKS_PER_ROW(4)) dutSlow (
        .CC_LEVEL_SEQUENCER_CLOCK_50    (clk),
        .CC_LEVEL_SEQUENCER_RESET_InHigh(rstSlow),
        .seqBus                         (busSlow)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: per instance, whether a game is running or won,
    // level/row numbers, unpaused ticks since the last row, and the pulses.
    int tpr  [2] = '{1, 4};
    int lens [7] = '{0, 8, 10, 8, 15, 8, 20};
    bit mRun [2];
    bit mWin [2];
    int mLvl [2];
    int mProg[2];
    int mTicks[2];
    bit mRv  [2];
    bit mLd  [2];

    task automatic modelReset(input int d);
        mRun[d] = 0; mWin[d] = 0; mLvl[d] = 0; mProg[d] = 0;
        mTicks[d] = 0; mRv[d] = 0; mLd[d] = 0;
    endtask

    task automatic modelEdge(input int d, input logic startLow, input logic tick,
                             input logic pause, input logic crash);
        mRv[d] = 0;
        mLd[d] = 0;
        if (!mRun[d]) begin
            if (startLow == 1'b0) begin
                mRun[d] = 1; mWin[d] = 0; mLvl[d] = 1; mProg[d] = 0; mTicks[d] = 0;
            end
        end else if (crash && (mLvl[d] % 2 == 0)) begin
            mProg[d]  = 0;
            mTicks[d] = 0;
        end else if (tick && !pause) begin
            mTicks[d]++;
            if (mTicks[d] == tpr[d]) begin
                mTicks[d] = 0;
                if (mProg[d] < lens[mLvl[d]]) begin
                    mProg[d]++;
                    mRv[d] = 1;
                end else begin
                    mLd[d]   = 1;
                    mProg[d] = 0;
                    if (mLvl[d] == 6) begin
                        mRun[d] = 0;
                        mWin[d] = 1;
                    end else begin
                        mLvl[d]++;
                    end
                end
            end
        end
    endtask

    // Drive one instance for one clock edge, the other sees idle inputs.
    task automatic applyStimulus(input int d, input logic startLow, input logic tick,
                                 input logic pause, input logic crash);
        logic sL[2], tk[2], ps[2], cr[2];
        for (int i = 0; i < 2; i++) begin
            sL[i] = 1'b1; tk[i] = 1'b0; ps[i] = 1'b0; cr[i] = 1'b0;
        end
        sL[d] = startLow; tk[d] = tick; ps[d] = pause; cr[d] = crash;
        for (int i = 0; i < 2; i++) begin
            drvStartLow[i] = sL[i]; drvTick[i] = tk[i]; drvPause[i] = ps[i]; drvCrash[i] = cr[i];
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            modelEdge(i, sL[i], tk[i], ps[i], cr[i]);
            drvStartLow[i] = 1'b1; drvTick[i] = 1'b0; drvPause[i] = 1'b0; drvCrash[i] = 1'b0;
        end
    endtask

    // Compare every output of one instance with the model.
    task automatic checkOutput(input int d, input string tag);
        logic [2:0] obsLvl, expLvl;
        logic [4:0] obsProg, expProg;
        logic       obsRv, obsLd, obsWin;
        if (d == 0) begin
            obsLvl  = busFast.CC_LEVEL_SEQUENCER_CurrentLvl_OutBus;
            obsProg = busFast.CC_LEVEL_SEQUENCER_LvlProgress_OutBus;
            obsRv   = busFast.CC_LEVEL_SEQUENCER_RowValid_Out;
            obsLd   = busFast.CC_LEVEL_SEQUENCER_LevelDone_Out;
            obsWin  = busFast.CC_LEVEL_SEQUENCER_Win_Out;
        end else begin
            obsLvl  = busSlow.CC_LEVEL_SEQUENCER_CurrentLvl_OutBus;
            obsProg = busSlow.CC_LEVEL_SEQUENCER_LvlProgress_OutBus;
            obsRv   = busSlow.CC_LEVEL_SEQUENCER_RowValid_Out;
            obsLd   = busSlow.CC_LEVEL_SEQUENCER_LevelDone_Out;
            obsWin  = busSlow.CC_LEVEL_SEQUENCER_Win_Out;
        end
        expLvl  = 3'(mLvl[d]);
        expProg = 5'(mProg[d]);
        checks++;
        assert (obsLvl === expLvl) else begin
            failures++;
            $error("[TB] FAIL %s/lvl dut%0d: observed=%0d expected=%0d", tag, d, obsLvl, expLvl);
        end
        checks++;
        assert (obsProg === expProg) else begin
            failures++;
            $error("[TB] FAIL %s/progress dut%0d: observed=%0d expected=%0d", tag, d, obsProg, expProg);
        end
        checks++;
        assert (obsRv === mRv[d]) else begin
            failures++;
            $error("[TB] FAIL %s/rowValid dut%0d: observed=%b expected=%b", tag, d, obsRv, mRv[d]);
        end
        checks++;
        assert (obsLd === mLd[d]) else begin
            failures++;
            $error("[TB] FAIL %s/levelDone dut%0d: observed=%b expected=%b", tag, d, obsLd, mLd[d]);
        end
        checks++;
        assert (obsWin === mWin[d]) else begin
            failures++;
            $error("[TB] FAIL %s/win dut%0d: observed=%b expected=%b", tag, d, obsWin, mWin[d]);
        end
    endtask

    task automatic step(input int d, input logic startLow, input logic tick,
                        input logic pause, input logic crash, input string tag);
        applyStimulus(d, startLow, tick, pause, crash);
        checkOutput(d, tag);
    endtask

    // Random ticks and pauses (no crash) until the model reaches a target.
    task automatic runUntil(input int d, input int lvl, input int prog,
                            input bit wantWin, input string tag);
        int  n = 0;
        bit  reached;
        while (!(mLvl[d] == lvl && mProg[d] == prog && mWin[d] == wantWin
                 && mRun[d] == !wantWin) && n < 3000) begin
            step(d, 1'b1, ($urandom_range(0, 3) != 0), ($urandom_range(0, 4) == 0), 1'b0, tag);
            n++;
        end
        reached = (mLvl[d] == lvl && mProg[d] == prog && mWin[d] == wantWin);
        checks++;
        assert (reached === 1'b1) else begin
            failures++;
            $error("[TB] FAIL %s/bound: reached=%0d required=1", tag, reached);
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            drvStartLow[i] = 1'b1; drvTick[i] = 1'b0; drvPause[i] = 1'b0; drvCrash[i] = 1'b0;
            modelReset(i);
        end
        rstFast = 1'b1;
        rstSlow = 1'b1;
        #12;
        checkOutput(0, "resetFast");
        checkOutput(1, "resetSlow");
        #1;
        rstFast = 1'b0;
        rstSlow = 1'b0;

        // Idle ignores tick, pause and crash.
        step(0, 1'b1, 1'b1, 1'b1, 1'b1, "idleIgnore");
        step(0, 1'b1, 1'b1, 1'b0, 1'b0, "idleTick");

        // Start, then level 1 row by row with random idle gaps.
        step(0, 1'b0, 1'b0, 1'b0, 1'b0, "start");
        for (int r = 0; r < 8; r++) begin
            int gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) step(0, 1'b1, 1'b0, 1'b0, 1'b0, "lvl1Gap");
            step(0, 1'b1, 1'b1, 1'b0, 1'b0, "lvl1Row");
        end
        step(0, 1'b1, 1'b1, 1'b0, 1'b0, "lvl1Done");
        step(0, 1'b1, 1'b0, 1'b0, 1'b0, "pulseClear");

        // Start pulse at level 2 row 4 is ignored.
        for (int r = 0; r < 4; r++) step(0, 1'b1, 1'b1, 1'b0, 1'b0, "lvl2Row");
        step(0, 1'b0, 1'b0, 1'b0, 1'b0, "startInRun");
        step(0, 1'b1, 1'b1, 1'b0, 1'b0, "afterStart");

        // Banner crash ignored, play crash beats a same-cycle step.
        runUntil(0, 3, 5, 1'b0, "toLvl3");
        step(0, 1'b1, 1'b0, 1'b0, 1'b1, "bannerCrash");
        runUntil(0, 4, 9, 1'b0, "toLvl4");
        step(0, 1'b1, 1'b1, 1'b0, 1'b1, "playCrashStep");

        // Run through to WIN, confirm it is frozen, then restart.
        runUntil(0, 6, 0, 1'b1, "toWin");
        for (int k = 0; k < 3; k++) step(0, 1'b1, 1'b1, 1'b0, 1'b1, "winFrozen");
        step(0, 1'b0, 1'b0, 1'b0, 1'b0, "winRestart");

        // Asynchronous reset in the middle of level 6.
        runUntil(0, 6, 12, 1'b0, "toLvl6");
        #2;
        rstFast = 1'b1;
        #1;
        modelReset(0);
        checkOutput(0, "asyncReset");
        #2;
        rstFast = 1'b0;
        step(0, 1'b1, 1'b1, 1'b0, 1'b0, "tickAfterReset");

        // Divide-by-four instance: pacing, pause freeze, crash clears prescaler.
        step(1, 1'b0, 1'b0, 1'b0, 1'b0, "slowStart");
        runUntil(1, 2, 0, 1'b0, "slowToLvl2");
        for (int k = 0; k < 4; k++) step(1, 1'b1, 1'b1, 1'b0, 1'b0, "slowDivide");
        for (int k = 0; k < 2; k++) step(1, 1'b1, 1'b1, 1'b0, 1'b0, "slowPre");
        for (int k = 0; k < 10; k++) step(1, 1'b1, 1'b1, 1'b1, 1'b0, "slowPaused");
        for (int k = 0; k < 2; k++) step(1, 1'b1, 1'b1, 1'b0, 1'b0, "slowResume");
        for (int k = 0; k < 2; k++) step(1, 1'b1, 1'b1, 1'b0, 1'b0, "slowPreCrash");
        step(1, 1'b1, 1'b0, 1'b0, 1'b1, "slowCrash");
        for (int k = 0; k < 4; k++) step(1, 1'b1, 1'b1, 1'b0, 1'b0, "slowPostCrash");
        step(1, 1'b1, 1'b1, 1'b1, 1'b1, "crashWhilePaused");

        // Random traffic on the slow instance, including crashes and starts.
        for (int k = 0; k < 150; k++) begin
            step(1, ($urandom_range(0, 9) != 0), ($urandom_range(0, 2) != 0),
                 ($urandom_range(0, 4) == 0), ($urandom_range(0, 11) == 0), "slowRandom");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
